// File: rtl/exec_pipe_pkg.sv
// Shared constants and bundle layout for the decode-to-execute pipeline register.
// The struct uses the default widths (64-bit words, 4-bit register IDs).
package exec_pipe_pkg;

    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [3:0] INOP  = 4'd1;
    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } exec_bundle_t;

    function automatic exec_bundle_t nop_bundle();
        exec_bundle_t b;
        b = '{stat: SAOK, icode: INOP, ifun: 4'd0, valC: 64'd0, valA: 64'd0, valB: 64'd0,
              dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};
        return b;
    endfunction

endpackage

// File: rtl/exec_bundle_slot.sv
// One bundle register: reset and clear force the NOP pattern, load captures d.
// Clear wins over load so a bubble always leaves a NOP behind.
module exec_bundle_slot #(
    parameter int         W       = 1,
    parameter logic [W-1:0] NOP_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= NOP_VAL;
        end else if (clear) begin
            q <= NOP_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exec_pipe_reg.sv
// Decode-to-execute pipeline register with stall, bubble and a saturating bubble counter.
// Define EXEC_PIPE_REG_SKID_EN for a 2-entry skid version whose in_ready has no path from out_ready.
module exec_pipe_reg
    import exec_pipe_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              bubble,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [2:0]        D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [WORD_W-1:0] D_valC,
    input  logic [WORD_W-1:0] d_valA,
    input  logic [WORD_W-1:0] d_valB,
    input  logic [REG_W-1:0]  d_dstE,
    input  logic [REG_W-1:0]  d_dstM,
    input  logic [REG_W-1:0]  d_srcA,
    input  logic [REG_W-1:0]  d_srcB,
    output logic [2:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [WORD_W-1:0] E_valC,
    output logic [WORD_W-1:0] E_valA,
    output logic [WORD_W-1:0] E_valB,
    output logic [REG_W-1:0]  E_dstE,
    output logic [REG_W-1:0]  E_dstM,
    output logic [REG_W-1:0]  E_srcA,
    output logic [REG_W-1:0]  E_srcB,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Handshake: a bundle moves in when in_valid & in_ready and out when out_valid & out_ready,
    // both evaluated at the same rising edge; reset, bubble and stall suppress both sides.
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [WORD_W-1:0] valC;
        logic [WORD_W-1:0] valA;
        logic [WORD_W-1:0] valB;
        logic [REG_W-1:0]  dstE;
        logic [REG_W-1:0]  dstM;
        logic [REG_W-1:0]  srcA;
        logic [REG_W-1:0]  srcB;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    // Register IDs widen as all-ones so RNONE keeps its meaning at any REG_W.
    localparam bundle_t NOP_B = '{stat: SAOK, icode: INOP, ifun: '0,
                                  valC: '0, valA: '0, valB: '0,
                                  dstE: '1, dstM: '1, srcA: '1, srcB: '1};

    bundle_t d_bundle;
    bundle_t main_d;
    bundle_t main_q;
    logic    full;
    logic    main_load;
    logic    in_fire;
    logic    out_fire;

    assign d_bundle = {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
                       d_dstE, d_dstM, d_srcA, d_srcB};
    assign {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
            E_dstE, E_dstM, E_srcA, E_srcB} = main_q;

    assign out_valid = rst_n & full & ~stall & ~bubble;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef EXEC_PIPE_REG_SKID_EN
    logic    skid_full;
    logic    skid_load;
    bundle_t skid_q;

    assign in_ready  = rst_n & ~stall & ~bubble & ~skid_full;
    // A held skid entry is promoted on drain; skid is only ever full when main is full.
    assign main_load = (out_fire & skid_full) | (in_fire & (~full | out_fire));
    assign main_d    = skid_full ? skid_q : d_bundle;
    assign skid_load = in_fire & full & ~out_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full      <= 1'b0;
            skid_full <= 1'b0;
        end else if (bubble) begin
            full      <= 1'b0;
            skid_full <= 1'b0;
        end else if (!stall) begin
            if (out_fire) begin
                if (skid_full) begin
                    skid_full <= 1'b0;
                end else begin
                    full <= in_fire;
                end
            end else if (in_fire) begin
                if (full) begin
                    skid_full <= 1'b1;
                end else begin
                    full <= 1'b1;
                end
            end
        end
    end

    exec_bundle_slot #(
        .W       (BW),
        .NOP_VAL (NOP_B)
    ) u_skid_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (bubble),
        .d     (d_bundle),
        .q     (skid_q)
    );
`else
    assign in_ready  = rst_n & ~stall & ~bubble & (~full | out_ready);
    assign main_load = in_fire;
    assign main_d    = d_bundle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (bubble) begin
            full <= 1'b0;
        end else if (!stall) begin
            if (in_fire) begin
                full <= 1'b1;
            end else if (out_fire) begin
                full <= 1'b0;
            end
        end
    end
`endif

    exec_bundle_slot #(
        .W       (BW),
        .NOP_VAL (NOP_B)
    ) u_main_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (bubble),
        .d     (main_d),
        .q     (main_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_exec_pipe_reg.sv
// Bench for exec_pipe_reg: vector table plus scoreboard, hand sequences for saturation and reset.
// Expectations follow EXEC_PIPE_REG_SKID_EN when it is defined for the whole build.
module tb_exec_pipe_reg;
    import exec_pipe_pkg::*;

    localparam int WW = 64;
    localparam int RW = 4;
    localparam int BW = 11 + 3 * WW + 4 * RW;
`ifdef EXEC_PIPE_REG_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid, stall, bubble, out_ready;
    logic [2:0]    D_stat;
    logic [3:0]    D_icode, D_ifun;
    logic [WW-1:0] D_valC, d_valA, d_valB;
    logic [RW-1:0] d_dstE, d_dstM, d_srcA, d_srcB;

    logic          in_ready, out_valid;
    logic [2:0]    E_stat;
    logic [3:0]    E_icode, E_ifun;
    logic [WW-1:0] E_valC, E_valA, E_valB;
    logic [RW-1:0] E_dstE, E_dstM, E_srcA, E_srcB;
    logic [15:0]   bubble_cnt;

    logic          s_in_ready, s_out_valid;
    logic [2:0]    s_E_stat;
    logic [3:0]    s_E_icode, s_E_ifun;
    logic [WW-1:0] s_E_valC, s_E_valA, s_E_valB;
    logic [RW-1:0] s_E_dstE, s_E_dstM, s_E_srcA, s_E_srcB;
    logic [3:0]    s_bubble_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [BW-1:0] exp_q[$];

    exec_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .bubble(bubble), .out_valid(out_valid), .out_ready(out_ready),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC),
        .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .bubble_cnt(bubble_cnt)
    );

    // Narrow counter copy so saturation is reachable in a few cycles.
    exec_pipe_reg #(.WORD_W(WW), .REG_W(RW), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .stall(stall), .bubble(bubble), .out_valid(s_out_valid), .out_ready(out_ready),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_valC(D_valC),
        .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(s_E_stat), .E_icode(s_E_icode), .E_ifun(s_E_ifun), .E_valC(s_E_valC),
        .E_valA(s_E_valA), .E_valB(s_E_valB), .E_dstE(s_E_dstE), .E_dstM(s_E_dstM),
        .E_srcA(s_E_srcA), .E_srcB(s_E_srcB), .bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [BW-1:0] mk(input logic [3:0] ic);
        return {3'd1, ic, ~ic, {16{ic}}, {16{ic ^ 4'hA}}, {16{~ic}},
                ic, ic + 4'd1, ic ^ 4'h3, 4'hF - ic};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic iv, input logic [3:0] ic, input logic ordy,
                         input logic st, input logic bb);
        logic [BW-1:0] exp_b;
        logic [BW-1:0] act_b;
        @(negedge clk);
        in_valid = iv;
        {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB} = mk(ic);
        out_ready = ordy;
        stall = st;
        bubble = bb;
        #1;
        if (!rst_n || bb) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                act_b = {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
                         E_dstE, E_dstM, E_srcA, E_srcB};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual_icode=%0h required=none", E_icode);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (act_b !== exp_b) begin
                        failures++;
                        $display("FAIL sb_bundle actual_icode=%0h required_icode=%0h",
                                 E_icode, exp_b[BW-4 -: 4]);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(mk(ic));
        end
        if (rst_n && bb) exp_cnt++;
    endtask

    typedef struct {
        logic       iv;
        logic [3:0] ic;
        logic       ordy;
        logic       st;
        logic       bb;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_ic;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // stream, backpressure, stall, bubble+stall
        tbl[0]  = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[1]  = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2};
        tbl[2]  = '{1'b1, 4'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3};
        tbl[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6};
        tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6};
        tbl[5]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6};
        tbl[6]  = '{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, SKID, 1'b1, 4'd7};
        tbl[7]  = '{1'b1, SKID ? 4'd9 : 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7};
        tbl[8]  = '{1'b1, SKID ? 4'd9 : 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7};
        tbl[9]  = '{1'b1, SKID ? 4'd9 : 4'd8, 1'b1, 1'b0, 1'b0, ~SKID, 1'b1, 4'd7};
        tbl[10] = '{1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8};
        tbl[11] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9};
        tbl[12] = '{1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9};
        for (int i = 13; i <= 16; i++) tbl[i] = '{1'b1, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10};
        tbl[17] = '{1'b1, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10};
        tbl[18] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, SKID, 1'b1, 4'd11};
        tbl[19] = '{1'b1, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11};
        tbl[20] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};

        rst_n = 1'b0;
        in_valid = 1'b0; stall = 1'b0; bubble = 1'b0; out_ready = 1'b0;
        {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB} = '0;
        @(negedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_E_icode", 64'(E_icode), 64'(INOP));
        chk("rst_E_stat", 64'(E_stat), 64'(SAOK));
        chk("rst_E_dstE", 64'(E_dstE), 64'(RNONE));
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].iv, tbl[i].ic, tbl[i].ordy, tbl[i].st, tbl[i].bb);
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("v%0d_E_icode", i), 64'(E_icode), 64'(tbl[i].e_ic));
        end
        chk("bubble_cnt_one", 64'(bubble_cnt), 64'd1);
        chk("bubble_E_srcB", 64'(E_srcB), 64'hF);
        chk("bubble_E_valC", E_valC, 64'd0);

        // counter saturation on the narrow copy, continued counting on the wide one
        repeat (13) apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("cnt_14", 64'(bubble_cnt), 64'(exp_cnt));
        chk("small_cnt_14", 64'(s_bubble_cnt), 64'(exp_cnt > 15 ? 15 : exp_cnt));
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("small_cnt_15", 64'(s_bubble_cnt), 64'hF);
        repeat (2) apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("cnt_17", 64'(bubble_cnt), 64'(exp_cnt));
        chk("small_cnt_sat", 64'(s_bubble_cnt), 64'hF);

        // reset with main (and skid, when present) occupied
        apply(1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_E_icode", 64'(E_icode), 64'd13);
        rst_n = 1'b0;
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_E_icode", 64'(E_icode), 64'(INOP));
        chk("midrst_cnt", 64'(bubble_cnt), 64'd0);
        chk("midrst_small_cnt", 64'(s_bubble_cnt), 64'd0);
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("midrst_no_skid", 64'(out_valid), 64'd0);

        // traffic resumes after reset, random payloads through the scoreboard
        for (int i = 0; i < 12; i++) begin
            apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        repeat (4) apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
